round_enc: RTL and testbench
============================

ROUND_ENC -- requirements
Module: round_enc

Interface
REQ-001 Parameters: none; AES-128 only, 10 rounds fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to encrypt IN under KEY; sampled only in IDLE.
REQ-005 IN  input  128  plaintext block; byte 0 = IN[127:120], FIPS-197 column-major order.
REQ-006 KEY  input  128  cipher key, same byte order as IN.
REQ-007 ENC  output  128  ciphertext register, same byte order.
REQ-008 busy  output  1  high while a block is in progress.
REQ-009 done  output  1  one-cycle pulse; ENC valid and updated.

Function
REQ-010 FSM states SHALL be IDLE and ROUND; done SHALL be a registered flag, not a state.
REQ-011 In IDLE with start=1 at edge N, block SHALL capture state = IN ^ KEY, round key = KEY, round counter = 1, go to ROUND, and set busy=1.
REQ-012 IN and KEY SHALL be sampled only at edge N; later changes SHALL NOT affect the result.
REQ-013 At each edge in ROUND, block SHALL compute the next round key (RotWord, SubWord, Rcon XOR, word chaining) and update the state with SubBytes, ShiftRows, MixColumns, AddRoundKey, using the new round key.
REQ-014 Rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex), generated by GF(2^8) doubling mod 0x11b or by a table.
REQ-015 Round 10 SHALL omit MixColumns.
REQ-016 One round SHALL complete per cycle; rounds 1..10 SHALL occur at edges N+1..N+10.
REQ-017 At edge N+10, ENC SHALL load the final state, done SHALL become 1, busy SHALL become 0, and the FSM SHALL return to IDLE.
REQ-018 done SHALL fall at edge N+11; done is high for exactly one cycle per block.
REQ-019 ENC SHALL hold its value until the next completion or reset.
REQ-020 start SHALL be ignored while busy=1; no queuing.
REQ-021 start=1 sampled at edge N+11, while done=1, SHALL be accepted; back-to-back throughput SHALL be one block per 11 cycles.
REQ-022 Held start in IDLE SHALL launch a new block on each return to IDLE.
REQ-023 S-box SHALL be combinational (16 for SubBytes plus 4 for SubWord); no memories.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, ENC=0, busy=0, done=0, round counter=0, and internal state and round key = 0.
REQ-025 reset SHALL take priority over start and over any in-progress round.
REQ-026 reset mid-operation SHALL abort the block; done SHALL NOT pulse for the aborted block.
REQ-027 Outputs SHALL be undefined-free (no X) from the first edge with reset=1.

Verification
REQ-028 FIPS-197 C.1: IN=00112233445566778899aabbccddeeff, KEY=000102030405060708090a0b0c0d0e0f, start 1 cycle -> done exactly 10 edges later, ENC=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-029 FIPS-197 App.B: IN=3243f6a8885a308d313198a2e0370734, KEY=2b7e151628aed2a6abf7158809cf4f3c -> ENC=3925841d02dc09fbdc118597196a0b32, busy high for 10 cycles.
REQ-030 Back-to-back: start held high, C.1 then App.B vectors swapped in on the cycle done=1 -> two done pulses 11 cycles apart with the correct ENC each time.
REQ-031 Ignored start and input stability: pulse start and change IN/KEY at edges N+3 and N+5 -> ENC still equals the vector captured at edge N, and only one done pulse occurs.
REQ-032 Reset mid-block: reset=1 at edge N+5 for 2 cycles -> ENC=0, busy=0, no done pulse; a following C.1 run produces the correct ENC.
REQ-033 Power-up: reset=1 for 2 cycles with start=1 -> busy=0, done=0, ENC=0 throughout reset.

Source files
------------

// File: rtl/round_enc.sv
// AES-128 encryptor, one full round per clock (10 rounds), with on-the-fly key expansion.
// A block is launched from IDLE on start and finishes with a one-cycle done pulse and ENC updated.
module round_enc (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] IN,
    input  logic [127:0] KEY,
    output logic [127:0] ENC,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] enc_reg;
    logic [3:0]   round_reg;
    logic [7:0]   rcon_reg;
    logic         done_reg;

    logic         load;
    logic         step;
    logic         finish;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        inv  = gmul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Key schedule: next round key from the current one.
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  temp_word;
    logic [127:0] key_next;

    assign rot_word = {key_reg[23:0], key_reg[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
        end
    endgenerate

    assign temp_word            = sub_word ^ {rcon_reg, 24'h000000};
    assign key_next[127:96]     = key_reg[127:96] ^ temp_word;
    assign key_next[95:64]      = key_reg[95:64]  ^ key_next[127:96];
    assign key_next[63:32]      = key_reg[63:32]  ^ key_next[95:64];
    assign key_next[31:0]       = key_reg[31:0]   ^ key_next[63:32];

    // Round datapath; byte k of the block sits at bits [127-8k -: 8], row k%4, column k/4.
    logic [7:0]   sb_byte [16];
    logic [7:0]   sr_byte [16];
    logic [7:0]   mc_byte [16];
    logic [127:0] round_out;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            localparam int COL = gi / 4;
            localparam int ROW = gi % 4;
            assign sb_byte[gi] = sbox(state_reg[127-8*gi -: 8]);
            assign sr_byte[gi] = sb_byte[4*((COL + ROW) % 4) + ROW];
            assign round_out[127-8*gi -: 8] =
                (finish ? sr_byte[gi] : mc_byte[gi]) ^ key_next[127-8*gi -: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_mixcol
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr_byte[4*gi];
            assign a1 = sr_byte[4*gi+1];
            assign a2 = sr_byte[4*gi+2];
            assign a3 = sr_byte[4*gi+3];
            assign mc_byte[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mc_byte[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mc_byte[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mc_byte[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE:    if (start) fsm_next = ROUND;
            ROUND:   if (round_reg == 4'd10) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (fsm_reg)
            IDLE: begin
                load = start;
            end
            ROUND: begin
                busy   = 1'b1;
                step   = 1'b1;
                finish = (round_reg == 4'd10);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= '0;
            key_reg   <= '0;
            enc_reg   <= '0;
            round_reg <= '0;
            rcon_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= finish;
            if (load) begin
                state_reg <= IN ^ KEY;
                key_reg   <= KEY;
                round_reg <= 4'd1;
                rcon_reg  <= 8'h01;
            end else if (step) begin
                state_reg <= round_out;
                key_reg   <= key_next;
                rcon_reg  <= xtime(rcon_reg);
                round_reg <= finish ? 4'd0 : round_reg + 4'd1;
                if (finish) enc_reg <= round_out;
            end
        end
    end

    assign ENC  = enc_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_round_enc.sv
// Directed checks of round_enc against the FIPS-197 vectors: latency, busy window,
// back-to-back launch, ignored start, mid-block reset and power-up reset.
module tb_round_enc;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] in_blk;
    logic [127:0] key;
    logic [127:0] enc;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] C1_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_ENC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_IN   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_ENC  = 128'h3925841d02dc09fbdc118597196a0b32;

    round_enc dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .IN    (in_blk),
        .KEY   (key),
        .ENC   (enc),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Launch one block with a single-cycle start and check latency, busy window and result.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] ck,
                             input logic [127:0] exp);
        int lat;
        int busy_cnt;
        @(negedge clk);
        in_blk = pt;
        key    = ck;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_at_N"}, {127'd0, busy}, 128'd1);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'd10);
        check({tag, "_busy_low_at_done"}, {127'd0, busy}, 128'd0);
        check({tag, "_enc"}, enc, exp);
        @(posedge clk); #1;
        check({tag, "_done_falls"}, {127'd0, done}, 128'd0);
        check({tag, "_enc_holds"}, enc, exp);
    endtask

    initial begin
        int lat;
        int done_cnt;

        reset  = 1'b1;
        start  = 1'b1;
        in_blk = C1_IN;
        key    = C1_KEY;

        // Power-up reset with start asserted.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_busy", {127'd0, busy}, 128'd0);
            check("rst_done", {127'd0, done}, 128'd0);
            check("rst_enc", enc, 128'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        run_block("c1", C1_IN, C1_KEY, C1_ENC);
        run_block("appb", B_IN, B_KEY, B_ENC);

        // Back-to-back: start held, inputs swapped on the done cycle.
        @(negedge clk);
        in_blk = C1_IN;
        key    = C1_KEY;
        start  = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        check("b2b_first_latency", 128'(lat), 128'd10);
        check("b2b_first_enc", enc, C1_ENC);
        in_blk = B_IN;
        key    = B_KEY;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
        check("b2b_spacing", 128'(lat), 128'd11);
        check("b2b_second_enc", enc, B_ENC);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_no_third", {127'd0, busy}, 128'd0);

        // Start pulses and input changes mid-block are ignored.
        @(negedge clk);
        in_blk = C1_IN;
        key    = C1_KEY;
        start  = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        done_cnt = 0;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            start = 1'b0;
            if (e == 2 || e == 4) begin
                start  = 1'b1;
                in_blk = B_IN ^ 128'(e);
                key    = B_KEY;
            end
        end
        check("ign_done_count", 128'(done_cnt), 128'd1);
        check("ign_enc", enc, C1_ENC);

        // Reset at edge N+5 for two cycles aborts the block.
        @(negedge clk);
        in_blk = B_IN;
        key    = B_KEY;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_enc", enc, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_done", {127'd0, done}, 128'd0);
        reset    = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 128'(done_cnt), 128'd0);

        run_block("c1_after_abort", C1_IN, C1_KEY, C1_ENC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
